// File: rtl/gpu_mem_pkg.sv
// Shared memory map and protocol constants for the GPU column-buffer path.
// The display controller imports the same addresses and flag bit positions.
package gpu_mem_pkg;

  // Double-buffered distance/texture regions plus the handshake flag word.
  localparam logic [15:0] GPU_DIST0_BASE = 16'd63488;
  localparam logic [15:0] GPU_DIST1_BASE = 16'd64512;
  localparam logic [15:0] GPU_TEX0_BASE  = 16'd64000;
  localparam logic [15:0] GPU_TEX1_BASE  = 16'd64832;
  localparam logic [15:0] GPU_FLAG_ADDR  = 16'd65535;

  // Flag word: bit0 set by the display once a frame is consumed,
  // bit1 names the buffer currently on screen.
  localparam int FLAG_CONSUMED = 0;
  localparam int FLAG_BUFSEL   = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL,
    ST_POLL_CAP,
    ST_BACKOFF,
    ST_ACCEPT,
    ST_WR_DIST,
    ST_WR_TEX,
    ST_PUBLISH
  } cw_state_e;

  // 16-bit wrap-around address of a column slot; idx arrives zero-extended.
  function automatic logic [15:0] buf_addr(input logic [15:0] base, input logic [15:0] idx);
    return base + idx;
  endfunction

endpackage

// File: rtl/gpu_poll_timer.sv
// Back-off down-counter between flag polls. Loaded with INTERVAL, counts to
// zero and sits there; expired is high while the count is zero. A BACKOFF
// stay therefore spans INTERVAL+1 cycles, so a stale-flag poll repeats every
// INTERVAL+3 cycles (POLL + POLL_CAP + BACKOFF).
module gpu_poll_timer #(
  parameter int INTERVAL = 64
) (
  input  logic clk,
  input  logic clr,
  input  logic load,
  output logic expired
);

  localparam int CW = $clog2(INTERVAL + 1);

  logic [CW-1:0] count;

  // Load on request, otherwise decrement until zero.
  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (load)
      count <= CW'(INTERVAL);
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign expired = (count == '0);

endmodule

// File: rtl/gpu_column_writer.sv
// Producer side of the column-buffer protocol: waits for the display to mark
// the last frame consumed, streams COLUMNS (distance, texture) pairs into the
// back buffer, then publishes it by rewriting the flag word.
// All memory-port outputs are registered and only change on a granted
// operation or a state entry, so they hold steady while the port is denied.
module gpu_column_writer
  import gpu_mem_pkg::*;
#(
  parameter int          COLUMNS       = 320,
  parameter logic [15:0] DIST0_BASE    = GPU_DIST0_BASE,
  parameter logic [15:0] DIST1_BASE    = GPU_DIST1_BASE,
  parameter logic [15:0] TEX0_BASE     = GPU_TEX0_BASE,
  parameter logic [15:0] TEX1_BASE     = GPU_TEX1_BASE,
  parameter logic [15:0] FLAG_ADDR     = GPU_FLAG_ADDR,
  parameter int          POLL_INTERVAL = 64
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        col_valid,
  output logic        col_ready,
  input  logic [15:0] col_distance,
  input  logic [15:0] col_texture,
  output logic        mem_req,
  input  logic        mem_grant,
  output logic [15:0] address,
  output logic        write_enable,
  output logic [15:0] write_data,
  input  logic [15:0] read_data,
  output logic        busy,
  output logic        frame_done
);

  // A single-column frame still needs a 1-bit index register.
  localparam int               IDX_W    = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COLUMNS - 1);

  cw_state_e        state, state_d;
  logic [IDX_W-1:0] index, index_d;
  logic             back_buf, back_buf_d;
  logic [15:0]      flags_q, flags_d;
  logic [15:0]      tex_q, tex_d;

  logic             col_ready_d, mem_req_d, write_enable_d, frame_done_d;
  logic [15:0]      address_d, write_data_d;

  logic             granted;
  logic             timer_load, timer_expired;
  logic [15:0]      idx_ext;
  logic [15:0]      dist_addr, tex_addr;

  gpu_poll_timer #(.INTERVAL(POLL_INTERVAL)) u_poll_timer (
    .clk     (clk),
    .clr     (clr),
    .load    (timer_load),
    .expired (timer_expired)
  );

  assign granted   = mem_req && mem_grant;
  assign idx_ext   = 16'(index);
  assign dist_addr = buf_addr(back_buf ? DIST1_BASE : DIST0_BASE, idx_ext);
  assign tex_addr  = buf_addr(back_buf ? TEX1_BASE  : TEX0_BASE,  idx_ext);
  assign busy      = (state != ST_IDLE);

  // Next state plus next values of the registered port outputs.
  always_comb begin
    state_d        = state;
    index_d        = index;
    back_buf_d     = back_buf;
    flags_d        = flags_q;
    tex_d          = tex_q;
    col_ready_d    = 1'b0;
    mem_req_d      = mem_req;
    write_enable_d = write_enable;
    address_d      = address;
    write_data_d   = write_data;
    frame_done_d   = 1'b0;
    timer_load     = 1'b0;

    case (state)
      ST_IDLE: begin
        state_d        = ST_POLL;
        mem_req_d      = 1'b1;
        write_enable_d = 1'b0;
        address_d      = FLAG_ADDR;
      end

      ST_POLL: begin
        if (granted) begin
          state_d   = ST_POLL_CAP;
          mem_req_d = 1'b0;
        end
      end

      // read_data carries the flag word the cycle after the granted read.
      ST_POLL_CAP: begin
        flags_d = read_data;
        if (read_data[FLAG_CONSUMED]) begin
          back_buf_d  = ~read_data[FLAG_BUFSEL];
          index_d     = '0;
          state_d     = ST_ACCEPT;
          col_ready_d = 1'b1;
        end else begin
          state_d    = ST_BACKOFF;
          timer_load = 1'b1;
        end
      end

      ST_BACKOFF: begin
        if (timer_expired) begin
          state_d        = ST_POLL;
          mem_req_d      = 1'b1;
          write_enable_d = 1'b0;
          address_d      = FLAG_ADDR;
        end
      end

      // The distance goes straight into write_data; only texture needs a hold.
      ST_ACCEPT: begin
        col_ready_d = 1'b1;
        if (col_valid) begin
          col_ready_d    = 1'b0;
          tex_d          = col_texture;
          state_d        = ST_WR_DIST;
          mem_req_d      = 1'b1;
          write_enable_d = 1'b1;
          address_d      = dist_addr;
          write_data_d   = col_distance;
        end
      end

      ST_WR_DIST: begin
        if (granted) begin
          state_d      = ST_WR_TEX;
          address_d    = tex_addr;
          write_data_d = tex_q;
        end
      end

      ST_WR_TEX: begin
        if (granted) begin
          if (index == LAST_IDX) begin
            state_d      = ST_PUBLISH;
            address_d    = FLAG_ADDR;
            write_data_d = {flags_q[15:2], back_buf, 1'b0};
          end else begin
            index_d        = index + 1'b1;
            state_d        = ST_ACCEPT;
            col_ready_d    = 1'b1;
            mem_req_d      = 1'b0;
            write_enable_d = 1'b0;
          end
        end
      end

      ST_PUBLISH: begin
        if (granted) begin
          state_d        = ST_IDLE;
          mem_req_d      = 1'b0;
          write_enable_d = 1'b0;
          frame_done_d   = 1'b1;
        end
      end

      default: begin
        state_d        = ST_IDLE;
        mem_req_d      = 1'b0;
        write_enable_d = 1'b0;
      end
    endcase
  end

  // State, datapath and port registers; clr abandons any partial frame.
  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= ST_IDLE;
      index        <= '0;
      back_buf     <= 1'b0;
      flags_q      <= '0;
      tex_q        <= '0;
      col_ready    <= 1'b0;
      mem_req      <= 1'b0;
      write_enable <= 1'b0;
      address      <= '0;
      write_data   <= '0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_d;
      index        <= index_d;
      back_buf     <= back_buf_d;
      flags_q      <= flags_d;
      tex_q        <= tex_d;
      col_ready    <= col_ready_d;
      mem_req      <= mem_req_d;
      write_enable <= write_enable_d;
      address      <= address_d;
      write_data   <= write_data_d;
      frame_done   <= frame_done_d;
    end
  end

endmodule
